// File: rtl/imem_loader.sv
// Byte-stream program loader for the 12-bit instruction memory; holds the CPU in reset until a full image is written.
// Optional trailing XOR checksum is enabled by defining IMEM_LOADER_CHECKSUM_EN.
//
// state   | meaning
// --------+-----------------------------------------------
// S_IDLE  | waiting for start, CPU held in reset
// S_COUNT | expecting word count byte N
// S_LO    | expecting low byte of the next word
// S_HI    | expecting high byte (upper nibble must be 0)
// S_WR    | one-cycle instruction memory write
// S_CHK   | expecting checksum byte (checksum build only)
// S_DONE  | image complete, CPU released
// S_ERR   | load aborted, CPU held in reset
module imem_loader #(
   parameter int ADDR_W  = 4,
   parameter int DEPTH   = 16,
   parameter int INSTR_W = 12
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               start_i,
   input  logic               in_valid_i,
   input  logic [7:0]         in_data_i,
   output logic               in_ready_o,
   output logic               imem_we_o,
   output logic [ADDR_W-1:0]  imem_addr_o,
   output logic [INSTR_W-1:0] imem_wdata_o,
   output logic               cpu_reset_o,
   output logic               done_o,
   output logic               error_o
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_COUNT = 3'd1;
   localparam logic [2:0] S_LO    = 3'd2;
   localparam logic [2:0] S_HI    = 3'd3;
   localparam logic [2:0] S_WR    = 3'd4;
`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam logic [2:0] S_CHK   = 3'd5;
`endif
   localparam logic [2:0] S_DONE  = 3'd6;
   localparam logic [2:0] S_ERR   = 3'd7;

   localparam logic [7:0] DEPTH_B = 8'(DEPTH);

   logic [2:0]         state_q, state_d;
   logic [ADDR_W-1:0]  idx_q, idx_d;
   logic [ADDR_W:0]    n_q, n_d;
   logic [ADDR_W:0]    idx_inc;
   logic [7:0]         lo_q, lo_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [INSTR_W-1:0] wdata_q, wdata_d;
   logic               accept;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]         csum_q, csum_d;
`endif

   always_comb begin
      in_ready_o = 1'b0;
      case (state_q)
         S_COUNT, S_LO, S_HI: in_ready_o = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
         S_CHK:               in_ready_o = 1'b1;
`endif
         default:             in_ready_o = 1'b0;
      endcase
   end

   assign accept  = in_valid_i && in_ready_o;
   // Widened by one bit so index+1 == 16 compares correctly against N == 16.
   assign idx_inc = {1'b0, idx_q} + (ADDR_W+1)'(1);

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      n_d     = n_q;
      lo_d    = lo_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_d  = csum_q;
`endif
      case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (start_i) begin
               state_d = S_COUNT;
               idx_d   = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
               csum_d  = '0;
`endif
            end
         end
         S_COUNT: begin
            if (accept) begin
               if (in_data_i == 8'd0 || in_data_i > DEPTH_B) begin
                  state_d = S_ERR;
               end else begin
                  n_d     = in_data_i[ADDR_W:0];
                  state_d = S_LO;
               end
`ifdef IMEM_LOADER_CHECKSUM_EN
               csum_d = csum_q ^ in_data_i;
`endif
            end
         end
         S_LO: begin
            if (accept) begin
               lo_d    = in_data_i;
               state_d = S_HI;
`ifdef IMEM_LOADER_CHECKSUM_EN
               csum_d  = csum_q ^ in_data_i;
`endif
            end
         end
         S_HI: begin
            if (accept) begin
               if (in_data_i[7:4] != 4'd0) begin
                  state_d = S_ERR;
               end else begin
                  addr_d  = idx_q;
                  wdata_d = {in_data_i[3:0], lo_q};
                  state_d = S_WR;
               end
`ifdef IMEM_LOADER_CHECKSUM_EN
               csum_d = csum_q ^ in_data_i;
`endif
            end
         end
         S_WR: begin
            idx_d = idx_inc[ADDR_W-1:0];
            if (idx_inc < n_q) begin
               state_d = S_LO;
            end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
               state_d = S_CHK;
`else
               state_d = S_DONE;
`endif
            end
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         S_CHK: begin
            if (accept) begin
               state_d = (in_data_i == csum_q) ? S_DONE : S_ERR;
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         n_q     <= '0;
         lo_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         n_q     <= n_d;
         lo_q    <= lo_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum_q  <= csum_d;
`endif
      end
   end

   assign imem_we_o    = (state_q == S_WR);
   assign imem_addr_o  = addr_q;
   assign imem_wdata_o = wdata_q;
   assign cpu_reset_o  = (state_q != S_DONE);
   assign done_o       = (state_q == S_DONE);
   assign error_o      = (state_q == S_ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: vector table of streams plus hand sequences for timing, N==16 and mid-load reset.
// Streams carry checksum bytes when IMEM_LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        reset, start, in_valid;
   logic [7:0]  in_data;
   logic        in_ready, imem_we, cpu_reset, done, error;
   logic [3:0]  imem_addr;
   logic [11:0] imem_wdata;

   imem_loader dut (
      .clk_i(clk), .reset_i(reset), .start_i(start), .in_valid_i(in_valid),
      .in_data_i(in_data), .in_ready_o(in_ready), .imem_we_o(imem_we),
      .imem_addr_o(imem_addr), .imem_wdata_o(imem_wdata),
      .cpu_reset_o(cpu_reset), .done_o(done), .error_o(error)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   logic [15:0] wr_q[$];

   always @(posedge clk) if (imem_we) wr_q.push_back({imem_addr, imem_wdata});

   // s: stream bytes, first byte in the MSB; w: expected writes {addr,data}, first in the MSB
   typedef struct {
      int          nb;
      logic [63:0] s;
      int          gap;
      int          nw;
      logic [63:0] w;
      logic        ed;
      logic        ee;
   } vec_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam int NV = 8;
`else
   localparam int NV = 6;
`endif
   vec_t tbl[NV];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("start_ready", in_ready, 1);
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap, output logic ok);
      logic r;
      int   n;
      if (gap != 0) begin
         in_valid = 1'b0;
         in_data  = 8'hEE;
         n = $urandom_range(1, 3);
         repeat (n) tick();
      end
      in_valid = 1'b1;
      in_data  = b;
      ok = 1'b0;
      for (int k = 0; k < 10; k++) begin
         r = in_ready;
         tick();
         if (r) begin
            ok = 1'b1;
            break;
         end
      end
      in_valid = 1'b0;
      in_data  = 8'hEE;
   endtask

   task automatic run_vec(input int id, input vec_t v);
      logic ok;
      do_start();
      wr_q.delete();
      for (int i = 0; i < v.nb; i++) begin
         if (error) break;
         send_byte(v.s[63-8*i -: 8], v.gap, ok);
         if (!ok && !error) chk($sformatf("v%0d_accept_timeout", id), 0, 1);
      end
      repeat (3) tick();
      chk($sformatf("v%0d_nwrites", id), wr_q.size(), v.nw);
      for (int j = 0; j < v.nw; j++)
         if (j < wr_q.size()) chk($sformatf("v%0d_write%0d", id, j), wr_q[j], v.w[63-16*j -: 16]);
      chk($sformatf("v%0d_done", id), done, v.ed);
      chk($sformatf("v%0d_error", id), error, v.ee);
      chk($sformatf("v%0d_cpu_reset", id), cpu_reset, !v.ed);
      chk($sformatf("v%0d_in_ready", id), in_ready, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic ok, ok_all;

`ifdef IMEM_LOADER_CHECKSUM_EN
      tbl[0] = '{8, 64'h03_14_00_A5_08_FF_0F_4A, 0, 3, 64'h0014_18A5_2FFF_0000, 1'b1, 1'b0};
      tbl[1] = '{8, 64'h03_14_00_A5_08_FF_0F_4A, 1, 3, 64'h0014_18A5_2FFF_0000, 1'b1, 1'b0};
      tbl[4] = '{4, 64'h01_7F_03_7D_00_00_00_00, 0, 1, 64'h037F_0000_0000_0000, 1'b1, 1'b0};
      tbl[6] = '{4, 64'h01_14_00_15_00_00_00_00, 0, 1, 64'h0014_0000_0000_0000, 1'b1, 1'b0};
      tbl[7] = '{4, 64'h01_14_00_16_00_00_00_00, 1, 1, 64'h0014_0000_0000_0000, 1'b0, 1'b1};
`else
      tbl[0] = '{7, 64'h03_14_00_A5_08_FF_0F_00, 0, 3, 64'h0014_18A5_2FFF_0000, 1'b1, 1'b0};
      tbl[1] = '{7, 64'h03_14_00_A5_08_FF_0F_00, 1, 3, 64'h0014_18A5_2FFF_0000, 1'b1, 1'b0};
      tbl[4] = '{3, 64'h01_7F_03_00_00_00_00_00, 0, 1, 64'h037F_0000_0000_0000, 1'b1, 1'b0};
`endif
      tbl[2] = '{1, 64'h00_00_00_00_00_00_00_00, 0, 0, 64'h0, 1'b0, 1'b1};
      tbl[3] = '{1, 64'h11_00_00_00_00_00_00_00, 0, 0, 64'h0, 1'b0, 1'b1};
      tbl[5] = '{5, 64'h02_14_00_22_18_00_00_00, 0, 1, 64'h0014_0000_0000_0000, 1'b0, 1'b1};

      reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'hEE;
      repeat (2) tick();
      reset = 1'b0;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_imem_we", imem_we, 0);
      chk("rst_imem_addr", imem_addr, 0);
      chk("rst_imem_wdata", imem_wdata, 0);
      chk("rst_cpu_reset", cpu_reset, 1);
      chk("rst_done", done, 0);
      chk("rst_error", error, 0);

      for (int i = 0; i < NV; i++) run_vec(i, tbl[i]);

      // Write timing: HI accepted at edge t gives exactly one imem_we cycle after t.
      do_start();
      send_byte(8'h01, 0, ok);
      send_byte(8'h7F, 0, ok);
      send_byte(8'h03, 0, ok);
      chk("t_we_high", imem_we, 1);
      chk("t_addr", imem_addr, 0);
      chk("t_wdata", imem_wdata, 12'h37F);
      chk("t_ready_in_wr", in_ready, 0);
      tick();
      chk("t_we_low", imem_we, 0);
      chk("t_wdata_hold", imem_wdata, 12'h37F);
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk("t_chk_ready", in_ready, 1);
      chk("t_chk_done_low", done, 0);
      send_byte(8'h7D, 0, ok);
`endif
      chk("t_done", done, 1);
      chk("t_cpu_released", cpu_reset, 0);

      // Full-depth image: index reaches 15 and stops without wrapping.
      do_start();
      wr_q.delete();
      ok_all = 1'b1;
      send_byte(8'h10, 0, ok);
      ok_all &= ok;
      for (int i = 0; i < 16; i++) begin
         send_byte(8'(i), 0, ok);
         ok_all &= ok;
         send_byte(8'(i), 0, ok);
         ok_all &= ok;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(8'h10, 0, ok);
      ok_all &= ok;
`endif
      repeat (2) tick();
      chk("n16_accept", ok_all, 1);
      chk("n16_nwrites", wr_q.size(), 16);
      for (int j = 0; j < 16; j++)
         if (j < wr_q.size()) chk($sformatf("n16_write%0d", j), wr_q[j], {4'(j), 4'(j), 8'(j)});
      chk("n16_done", done, 1);

      // Reset right after the first write abandons the load.
      do_start();
      wr_q.delete();
      send_byte(8'h03, 0, ok);
      send_byte(8'h14, 0, ok);
      send_byte(8'h00, 0, ok);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mr_nwrites", wr_q.size(), 1);
      chk("mr_in_ready", in_ready, 0);
      chk("mr_cpu_reset", cpu_reset, 1);
      chk("mr_done", done, 0);
      chk("mr_error", error, 0);
      run_vec(100, tbl[4]);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that writes the 12-bit instruction memory read by the 4-bit processor. It accepts a byte stream over a valid/ready handshake, assembles instruction words and writes them at incrementing addresses. It holds the processor in reset while loading and releases it once a complete, valid image is in memory.

## Interface
- ADDR_W, 4, instruction memory address width
- DEPTH, 16, number of instruction words; must be ≤ 2^ADDR_W
- INSTR_W, 12, instruction width; fixed at 12 (two bytes per word, high nibble of second byte unused)

- clk  in  1  system clock; the block has one clock
- reset  in  1  synchronous, active-high reset, sampled on rising clk
- start  in  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE and ERR
- in_valid  in  1  byte on in_data is valid
- in_data  in  8  stream byte
- in_ready  out  1  loader can accept a byte this cycle
- imem_we  out  1  instruction memory write enable
- imem_addr  out  ADDR_W  write address
- imem_wdata  out  INSTR_W  write data
- cpu_reset  out  1  processor reset; high except in DONE
- done  out  1  image loaded; processor running
- error  out  1  load aborted; processor held in reset

## Operation
- A byte transfers on a rising clk edge when in_valid && in_ready. in_ready depends only on state. The sender may hold or drop in_valid freely.
- Stream format:
  - count byte N, with 1 ≤ N ≤ DEPTH
  - N word pairs: LO = instr[7:0], then HI, where HI[3:0] = instr[11:8] and HI[7:4] must be 0
  - with IMEM_LOADER_CHECKSUM_EN only: a checksum byte
- States:
  - IDLE: in_ready=0. start → COUNT; word index := 0.
  - COUNT: in_ready=1. Accepted byte of 0 or > DEPTH → ERR. Otherwise latch N → LO.
  - LO: in_ready=1. Latch the byte → HI.
  - HI: in_ready=1. Accepted byte with HI[7:4] ≠ 0 → ERR, and no write for that word. Otherwise latch HI → WR.
  - WR: in_ready=0, imem_we=1, imem_addr=index, imem_wdata={HI[3:0],LO}. Increment index. If index+1 < N → LO; else CHK (macro defined) or DONE.
  - CHK: in_ready=1. Accepted byte equals running XOR → DONE; otherwise → ERR.
  - DONE: cpu_reset=0, done=1. start → COUNT, which asserts cpu_reset again.
  - ERR: error=1, cpu_reset=1. start → COUNT.
- Outputs are Moore (decoded from state):
  - cpu_reset = (state≠DONE)
  - done = (state==DONE)
  - error = (state==ERR)
  - imem_we = (state==WR)
  - imem_addr/imem_wdata hold their last value outside WR.
- start in COUNT/LO/HI/WR/CHK is ignored. Bytes presented while in_ready=0 are not consumed.
- Words beyond N are not written; memory above N keeps its old contents.
- Index arithmetic is ADDR_W bits. N==DEPTH==16 ends at the last write, at index 15, without wrap.

## Timing
- Reset values: in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_reset=1, done=0, error=0. State IDLE, index 0, checksum accumulator 0.
- reset asserted mid-load: next cycle the block is in IDLE, cpu_reset=1, and the partial image is abandoned. Already-written words are not erased.
- start at edge t → in_ready=1 from t+1.
- HI accepted at edge t → imem_we=1 during the cycle after t, for exactly one cycle. The next LO can be accepted at edge t+2 at the earliest.
- Best-case throughput: 3 cycles per word.
- Last WR cycle → done=1 and cpu_reset=0 in the following cycle (no checksum).
- Checksum accepted at edge t → done or error from t+1.
- Error byte accepted at edge t → error=1 from t+1. in_ready=0 from t+1.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined:
  - Running XOR covers the count byte and every LO and HI byte.
  - CHK state is present, and a trailing checksum byte is required.
  - A mismatched checksum leads to ERR with cpu_reset held, even though memory has been written.
- Undefined: no CHK state and no accumulator; WR after the last word → DONE.

## Test plan
- Load, macro undefined. Bytes 03,14,00,A5,08,FF,0F with in_valid always high → writes (0,0x014), (1,0x8A5), (2,0xFFF). Then done=1, cpu_reset=0.
- Backpressure. Same stream with in_valid low for 1–3 random cycles between bytes → identical writes and the same final state. No byte is lost or duplicated.
- Bad count. Count 00 → error=1, no imem_we. Count 11 (17) → error=1. Then start plus a valid stream → done=1.
- Bad HI. Bytes 02,14,00,22,18 → exactly one write (0,0x014), then error=1, cpu_reset=1.
- Mid-load reset. reset asserted after the first WR → IDLE, cpu_reset=1, in_ready=0. A fresh start with 01,7F,03 writes (0,0x37F).
- Checksum, macro defined. Bytes 01,14,00,15 → write (0,0x014), done=1. The same stream with checksum 16 → error=1 and cpu_reset stays 1.
